pcmb_encoder: RTL

- Closed-loop ADPCM-B (YM2610 delta-T) encoder. Compresses 16-bit signed PCM samples into 4-bit codes and packs two codes per byte, high nibble first, for sample ROM generation and loopback tests of the PCM-B playback path.
- Runs its own internal copy of the decoder's predictor and step-size update, so a bit-exact decoder reconstructs exactly the predictor values the encoder tracks.

---
 rtl/pcmb_encoder_if.sv | 22 ++
 rtl/pcmb_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcmb_encoder_if.sv
// Sample-in / byte-out handshake bundle for the ADPCM-B encoder.
// The producer/consumer side uses master, the encoder uses slave.
interface pcmb_encoder_if;
  logic        START;
  logic [15:0] PCM_IN;
  logic        PCM_VALID;
  logic        PCM_READY;
  logic        FLUSH;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_VALID;
  logic        BYTE_READY;

  modport master (
    output START, PCM_IN, PCM_VALID, FLUSH, BYTE_READY,
    input  PCM_READY, BYTE_OUT, BYTE_VALID
  );

  modport slave (
    input  START, PCM_IN, PCM_VALID, FLUSH, BYTE_READY,
    output PCM_READY, BYTE_OUT, BYTE_VALID
  );
endinterface

// File: rtl/pcmb_encoder.sv
// Closed-loop ADPCM-B (YM2610 delta-T) encoder: 16-bit PCM in, two 4-bit codes per byte out.
// Tracks the decoder's predictor and step size so a bit-exact decoder reconstructs acc exactly.
module pcmb_encoder #(
  parameter int DELTA_MIN = 127,
  parameter int DELTA_MAX = 24576
) (
  input  logic          CLK,
  input  logic          RESET,
  pcmb_encoder_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIFF     = 3'd1,
    SRCH2    = 3'd2,
    SRCH1    = 3'd3,
    SRCH0    = 3'd4,
    UPDATE   = 3'd5,
    WAIT_OUT = 3'd6
  } state_t;

  state_t             state_reg, state_next;
  logic signed [15:0] acc_reg;
  logic [14:0]        delta_reg;
  logic [15:0]        sample_reg;
  logic               sign_reg;
  logic [18:0]        mag4_reg;
  logic [18:0]        partial_reg;
  logic [2:0]         q_reg;
  logic [3:0]         high_reg;
  logic [3:0]         low_reg;
  logic               high_valid_reg;
  logic [7:0]         byte_reg;
  logic               byte_valid_reg;

  logic        out_free;
  logic        ready;
  logic        accept, do_start, load_byte, store_high, park_low, clear_high;
  logic [7:0]  byte_data;
  logic [3:0]  low_data;
  logic [3:0]  code;

  assign out_free       = !byte_valid_reg || bus.BYTE_READY;
  assign code           = {sign_reg, q_reg};
  assign bus.PCM_READY  = ready;
  assign bus.BYTE_OUT   = byte_reg;
  assign bus.BYTE_VALID = byte_valid_reg;

  // Difference against the predictor, magnitude pre-scaled by 4 for the search.
  logic [16:0] d17, mag17;
  assign d17   = {sample_reg[15], sample_reg} - {acc_reg[15], acc_reg};
  assign mag17 = d17[16] ? (~d17 + 17'd1) : d17;

  // Restoring search: one quotient bit per SRCH state.
  logic [1:0]  srch_bit;
  logic        srch_active;
  logic [18:0] trial;
  always_comb begin
    srch_bit    = 2'd0;
    srch_active = 1'b0;
    case (state_reg)
      SRCH2:   begin srch_bit = 2'd2; srch_active = 1'b1; end
      SRCH1:   begin srch_bit = 2'd1; srch_active = 1'b1; end
      SRCH0:   begin srch_bit = 2'd0; srch_active = 1'b1; end
      default: ;
    endcase
  end
  assign trial = partial_reg + (19'(delta_reg) << srch_bit);

  // (2q+1)*delta as a shift-add of delta.
  logic [18:0] odd_term [3];
  logic [18:0] odd_mult;
  logic [16:0] diff;
  for (genvar gi = 0; gi < 3; gi++) begin : g_odd
    assign odd_term[gi] = q_reg[gi] ? (19'(delta_reg) << (gi + 1)) : 19'd0;
  end
  assign odd_mult = 19'(delta_reg) + odd_term[0] + odd_term[1] + odd_term[2];
  assign diff     = {1'b0, odd_mult[18:3]};

  logic signed [17:0] acc_ext, diff_ext, acc_sum;
  logic signed [15:0] acc_sat;
  always_comb begin
    acc_ext  = {{2{acc_reg[15]}}, acc_reg};
    diff_ext = {1'b0, diff};
    acc_sum  = sign_reg ? (acc_ext - diff_ext) : (acc_ext + diff_ext);
    if (acc_sum > 18'sd32767)
      acc_sat = 16'sh7FFF;
    else if (acc_sum < -18'sd32768)
      acc_sat = -16'sh8000;
    else
      acc_sat = acc_sum[15:0];
  end

  logic [7:0]  t_mult;
  logic [22:0] delta_prod;
  logic [16:0] delta_scaled;
  logic [14:0] delta_new;
  always_comb begin
    case (q_reg)
      3'd4:    t_mult = 8'd77;
      3'd5:    t_mult = 8'd102;
      3'd6:    t_mult = 8'd128;
      3'd7:    t_mult = 8'd153;
      default: t_mult = 8'd57;
    endcase
    delta_prod   = {8'b0, delta_reg} * {15'b0, t_mult};
    delta_scaled = delta_prod[22:6];
    if (delta_scaled < 17'(DELTA_MIN))
      delta_new = 15'(DELTA_MIN);
    else if (delta_scaled > 17'(DELTA_MAX))
      delta_new = 15'(DELTA_MAX);
    else
      delta_new = delta_scaled[14:0];
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    accept     = 1'b0;
    do_start   = 1'b0;
    load_byte  = 1'b0;
    byte_data  = 8'h00;
    store_high = 1'b0;
    park_low   = 1'b0;
    low_data   = 4'h0;
    clear_high = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.START) begin
          do_start = 1'b1;
        end else if (bus.FLUSH) begin
          if (high_valid_reg) begin
            if (out_free) begin
              load_byte  = 1'b1;
              byte_data  = {high_reg, 4'h0};
              clear_high = 1'b1;
            end else begin
              park_low   = 1'b1;
              state_next = WAIT_OUT;
            end
          end
        end else begin
          ready = !RESET;
          if (bus.PCM_VALID && !RESET) begin
            accept     = 1'b1;
            state_next = DIFF;
          end
        end
      end
      DIFF:  state_next = SRCH2;
      SRCH2: state_next = SRCH1;
      SRCH1: state_next = SRCH0;
      SRCH0: state_next = UPDATE;
      UPDATE: begin
        state_next = IDLE;
        if (!high_valid_reg) begin
          store_high = 1'b1;
        end else if (out_free) begin
          load_byte  = 1'b1;
          byte_data  = {high_reg, code};
          clear_high = 1'b1;
        end else begin
          // Predictor still commits now; only the byte write is deferred.
          park_low   = 1'b1;
          low_data   = code;
          state_next = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (out_free) begin
          load_byte  = 1'b1;
          byte_data  = {high_reg, low_reg};
          clear_high = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_reg        <= '0;
      delta_reg      <= 15'(DELTA_MIN);
      sample_reg     <= '0;
      sign_reg       <= 1'b0;
      mag4_reg       <= '0;
      partial_reg    <= '0;
      q_reg          <= '0;
      high_reg       <= '0;
      low_reg        <= '0;
      high_valid_reg <= 1'b0;
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      if (accept)
        sample_reg <= bus.PCM_IN;
      if (do_start) begin
        acc_reg        <= '0;
        delta_reg      <= 15'(DELTA_MIN);
        high_valid_reg <= 1'b0;
      end
      if (state_reg == DIFF) begin
        sign_reg    <= d17[16];
        mag4_reg    <= {mag17, 2'b00};
        partial_reg <= '0;
        q_reg       <= '0;
      end
      if (srch_active && (trial <= mag4_reg)) begin
        partial_reg     <= trial;
        q_reg[srch_bit] <= 1'b1;
      end
      if (state_reg == UPDATE) begin
        acc_reg   <= acc_sat;
        delta_reg <= delta_new;
      end
      if (store_high) begin
        high_reg       <= code;
        high_valid_reg <= 1'b1;
      end
      if (park_low)
        low_reg <= low_data;
      if (clear_high)
        high_valid_reg <= 1'b0;
      // A new byte may load in the same cycle the previous one is taken.
      if (load_byte) begin
        byte_reg       <= byte_data;
        byte_valid_reg <= 1'b1;
      end else if (bus.BYTE_READY) begin
        byte_valid_reg <= 1'b0;
      end
    end
  end
endmodule
